// File: rtl/mac_reduce_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mac_reduce_pkg
//  Description : Width helpers and the round/saturate function shared by the
//                requantising stages of the MAC datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
package mac_reduce_pkg;

   // Wide signed working type for requantisation; every accumulator in the
   // datapath fits in it at realistic parameter values.
   typedef logic signed [63:0] wide_t;

   // Lane width out of group_mac: image x kernel product plus one carry bit.
   function automatic int calc_rw(input int img_w, input int ker_w);
      return img_w + ker_w + 1;
   endfunction

   // Width of the sum of all lanes.
   function automatic int calc_sw(input int rw, input int lanes);
      return rw + $clog2(lanes);
   endfunction

   // Accumulator width: lane sum plus room for 2^depth_w beats.
   function automatic int calc_aw(input int sw, input int depth_w);
      return sw + depth_w;
   endfunction

   // Round half up while dropping 'frac' fraction bits, then clamp to the
   // signed range of an out_w-bit word. The caller keeps the low out_w bits.
   function automatic wide_t round_sat(input wide_t v, input int frac, input int out_w);
      wide_t r;
      wide_t hi;
      wide_t lo;
      if (frac > 0) begin
         r = (v + (wide_t'(1) <<< (frac - 1))) >>> frac;
      end else begin
         r = v;
      end
      hi = (wide_t'(1) <<< (out_w - 1)) - wide_t'(1);
      lo = -(wide_t'(1) <<< (out_w - 1));
      if (r > hi) begin
         r = hi;
      end else if (r < lo) begin
         r = lo;
      end
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mac_reduce_if.sv
`default_nettype none
// ============================================================================
//  Module      : mac_reduce_if
//  Description : Lane-product input, configuration and valid/ready output
//                bundle of the MAC reduction stage.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mac_reduce_if
   import mac_reduce_pkg::*;
#(
   parameter int GROUP_NB    = 4,
   parameter int IMG_WIDTH   = 16,
   parameter int KER_WIDTH   = 8,
   parameter int DEPTH_WIDTH = 8
);
   localparam int c_RW = calc_rw(IMG_WIDTH, KER_WIDTH);

   logic [DEPTH_WIDTH-1:0]    cfg_len;
   logic                      cfg_relu;
   logic [GROUP_NB*c_RW-1:0]  result;
   logic                      val;
   logic [IMG_WIDTH-1:0]      data;
   logic                      data_val;
   logic                      data_rdy;
   logic                      ovf;

   // Producer / consumer side (upstream MAC plus next-layer sink).
   modport master (
      output cfg_len, cfg_relu, result, val, data_rdy,
      input  data, data_val, ovf
   );

   // Reduction stage side.
   modport slave (
      input  cfg_len, cfg_relu, result, val, data_rdy,
      output data, data_val, ovf
   );
endinterface
`default_nettype wire

// File: rtl/mac_reduce_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_2deep
//  Description : Two-entry FIFO built as head + tail registers so the head
//                word and its valid flag leave straight from flops.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_2deep #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [WIDTH-1:0] din_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] dout_o,
   output logic             valid_o,
   output logic             full_o
);
   logic [WIDTH-1:0] head_q;
   logic [WIDTH-1:0] tail_q;
   logic             head_val_q;
   logic             tail_val_q;

   // Head/tail shuffle; a push into a full FIFO is only taken when a pop
   // frees the head in the same cycle, otherwise it is discarded.
   always_ff @(posedge clk) begin
      if (!rst) begin
         head_q     <= '0;
         tail_q     <= '0;
         head_val_q <= 1'b0;
         tail_val_q <= 1'b0;
      end else if (pop_i && head_val_q) begin
         if (tail_val_q) begin
            head_q     <= tail_q;
            head_val_q <= 1'b1;
            tail_q     <= push_i ? din_i : tail_q;
            tail_val_q <= push_i;
         end else begin
            head_q     <= push_i ? din_i : head_q;
            head_val_q <= push_i;
         end
      end else if (push_i) begin
         if (!head_val_q) begin
            head_q     <= din_i;
            head_val_q <= 1'b1;
         end else if (!tail_val_q) begin
            tail_q     <= din_i;
            tail_val_q <= 1'b1;
         end
      end
   end

   assign dout_o  = head_q;
   assign valid_o = head_val_q;
   assign full_o  = tail_val_q;
endmodule
`default_nettype wire

// File: rtl/mac_reduce.sv
`default_nettype none
// ============================================================================
//  Module      : mac_reduce
//  Description : Sums group_mac lanes, accumulates over cfg_len+1 beats,
//                rounds/saturates/ReLU-clips to image format and buffers the
//                result on a valid/ready output.
//  Revision    : 1.0 - initial release
// ============================================================================
module mac_reduce
   import mac_reduce_pkg::*;
#(
   parameter int GROUP_NB    = 4,
   parameter int IMG_WIDTH   = 16,
   parameter int IMG_FIXED   = IMG_WIDTH / 4,
   parameter int KER_WIDTH   = 8,
   parameter int KER_FIXED   = KER_WIDTH / 2,
   parameter int DEPTH_WIDTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   mac_reduce_if.slave bus
);
   localparam int c_RW   = calc_rw(IMG_WIDTH, KER_WIDTH);
   localparam int c_SW   = calc_sw(c_RW, GROUP_NB);
   localparam int c_AW   = calc_aw(c_SW, DEPTH_WIDTH);
   // Lanes carry IMG_FIXED+KER_FIXED fraction bits; output keeps IMG_FIXED.
   localparam int c_DROP = (IMG_FIXED + KER_FIXED) - IMG_FIXED;

   // S1 state
   logic signed [c_SW-1:0]  sum_d;
   logic signed [c_SW-1:0]  sum_q;
   logic                    s1_val_q;
   logic [DEPTH_WIDTH-1:0]  s1_len_q;
   logic                    s1_relu_q;

   // S2 state
   logic [DEPTH_WIDTH-1:0]  cnt_q;
   logic [DEPTH_WIDTH-1:0]  len_q;
   logic                    relu_q;
   logic signed [c_AW-1:0]  acc_q;
   logic                    done_q;

   // S2/S3 combinational
   logic                    w_first;
   logic                    w_last;
   logic [DEPTH_WIDTH-1:0]  w_len;
   logic signed [c_AW-1:0]  w_sum_ext;
   logic [IMG_WIDTH-1:0]    w_rounded;
   logic [IMG_WIDTH-1:0]    w_word;

   // Output side
   logic                    w_full;
   logic                    w_pop;
   logic                    ovf_q;

   // Sign-extend every lane to the sum width and add them up.
   always_comb begin
      sum_d = '0;
      for (int k = 0; k < GROUP_NB; k++) begin
         sum_d = sum_d + c_SW'(signed'(bus.result[k*c_RW +: c_RW]));
      end
   end

   // S1: register the lane sum; cfg travels with the beat so it is sampled
   // in the same cycle as the first val of an accumulation.
   always_ff @(posedge clk) begin
      if (!rst) begin
         s1_val_q  <= 1'b0;
         sum_q     <= '0;
         s1_len_q  <= '0;
         s1_relu_q <= 1'b0;
      end else begin
         s1_val_q <= bus.val;
         if (bus.val) begin
            sum_q     <= sum_d;
            s1_len_q  <= bus.cfg_len;
            s1_relu_q <= bus.cfg_relu;
         end
      end
   end

   // First beat uses the freshly arriving length so single-beat runs finish
   // immediately; later beats compare against the latched one.
   assign w_first   = (cnt_q == '0);
   assign w_len     = w_first ? s1_len_q : len_q;
   assign w_last    = (cnt_q == w_len);
   assign w_sum_ext = c_AW'(sum_q);

   // S2: overwrite on the first beat, add afterwards; idle cycles hold.
   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_q  <= '0;
         len_q  <= '0;
         relu_q <= 1'b0;
         acc_q  <= '0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (s1_val_q) begin
            acc_q <= w_first ? w_sum_ext : acc_q + w_sum_ext;
            if (w_first) begin
               len_q  <= s1_len_q;
               relu_q <= s1_relu_q;
            end
            if (w_last) begin
               done_q <= 1'b1;
               cnt_q  <= '0;
            end else begin
               cnt_q  <= cnt_q + DEPTH_WIDTH'(1);
            end
         end
      end
   end

   // S3: requantise the finished total; the next accumulation may overwrite
   // acc_q at this same edge, which is fine since the word is pushed now.
   assign w_rounded = IMG_WIDTH'(round_sat(wide_t'(acc_q), c_DROP, IMG_WIDTH));
   assign w_word    = (relu_q && w_rounded[IMG_WIDTH-1]) ? '0 : w_rounded;

   assign w_pop = bus.data_val && bus.data_rdy;

   fifo_2deep #(
      .WIDTH (IMG_WIDTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (done_q),
      .din_i   (w_word),
      .pop_i   (w_pop),
      .dout_o  (bus.data),
      .valid_o (bus.data_val),
      .full_o  (w_full)
   );

   // Sticky flag for a completed word that found the buffer full.
   always_ff @(posedge clk) begin
      if (!rst) begin
         ovf_q <= 1'b0;
      end else if (done_q && w_full && !w_pop) begin
         ovf_q <= 1'b1;
      end
   end

   assign bus.ovf = ovf_q;
endmodule
`default_nettype wire
